// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the configuration SPI command transmitter.
// Holds the slave register map, frame length, FSM state type and command record.
package spi_pkg;

    localparam logic [7:0] ADDR_TRIG_MASK = 8'd1;
    localparam logic [7:0] ADDR_INSTR     = 8'd2;
    localparam logic [7:0] ADDR_MODE      = 8'd3;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } spi_tx_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } spi_cmd_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: small synchronous command FIFO placed in front of the transmitter.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module spi_tx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     iclk,
    input  logic     rstn,
    input  logic     push_i,
    input  spi_cmd_t wdata_i,
    input  logic     pop_i,
    output spi_cmd_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    spi_cmd_t        mem_q [DEPTH];
    logic [AW:0]     wrPtr_q, wrPtr_d;
    logic [AW:0]     rdPtr_q, rdPtr_d;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    // Pointer advance: a push into a full FIFO or a pop from an empty one is ignored.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push_i && !full_o) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Pointer registers; clearing them on reset empties the FIFO.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge iclk) begin
        if (push_i && !full_o) begin
            mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/spi_cmd_tx.sv
// spi_cmd_tx: shifts {data, addr} out LSB first as a 16-bit SPI frame, followed by an
// idle gap with sclk low. Optional macro SPI_TX_FIFO_EN puts a command FIFO in front.
module spi_cmd_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       iclk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       sclk,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    spi_tx_state_t    state_q, state_d;
    logic [15:0]      shiftReg_q, shiftReg_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [3:0]       bitIdx_q, bitIdx_d;
    logic             phase_q, phase_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             done_q, done_d;

    logic             start;
    spi_cmd_t         startCmd;
    logic             queued;
    logic             unusedAddrMap;

    assign unusedAddrMap = ^{ADDR_TRIG_MASK, ADDR_INSTR, ADDR_MODE};

`ifdef SPI_TX_FIFO_EN
    logic     fifoFull;
    logic     fifoEmpty;
    spi_cmd_t fifoRdata;
    spi_cmd_t fifoWdata;

    assign fifoWdata = '{addr: cmd_addr, data: cmd_data};
    assign cmd_ready = !fifoFull;
    assign start     = (state_q == ST_IDLE) && !fifoEmpty;
    assign startCmd  = fifoRdata;
    assign queued    = !fifoEmpty;

    spi_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iclk    (iclk),
        .rstn    (rstn),
        .push_i  (cmd_valid && !fifoFull),
        .wdata_i (fifoWdata),
        .pop_i   (start),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );
`else
    logic unusedFifoDepth;

    assign unusedFifoDepth = (FIFO_DEPTH != 0);
    assign cmd_ready = (state_q == ST_IDLE);
    assign start     = cmd_valid && cmd_ready;
    assign startCmd  = '{addr: cmd_addr, data: cmd_data};
    assign queued    = 1'b0;
`endif

    assign sclk       = sclk_q;
    assign serial_out = sdo_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE) || queued;

    // Next-state logic: load on start, walk low/high phases per bit, then count the gap.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        divCnt_d   = divCnt_q;
        gapCnt_d   = gapCnt_q;
        bitIdx_d   = bitIdx_q;
        phase_d    = phase_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    shiftReg_d = {startCmd.data, startCmd.addr};
                    sdo_d      = startCmd.addr[0];
                    sclk_d     = 1'b0;
                    divCnt_d   = '0;
                    bitIdx_d   = '0;
                    phase_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (divCnt_q == DIV_LAST) begin
                    divCnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bitIdx_q == LAST_BIT) begin
                            state_d  = ST_GAP;
                            sdo_d    = 1'b0;
                            gapCnt_d = '0;
                            done_d   = (GAP_LAST == '0);
                        end else begin
                            bitIdx_d   = bitIdx_q + 1'b1;
                            shiftReg_d = {1'b0, shiftReg_q[15:1]};
                            sdo_d      = shiftReg_q[1];
                        end
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                    done_d   = ((gapCnt_q + 1'b1) == GAP_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the frame in flight at once.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shiftReg_q <= '0;
            divCnt_q   <= '0;
            gapCnt_q   <= '0;
            bitIdx_q   <= '0;
            phase_q    <= 1'b0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            divCnt_q   <= divCnt_d;
            gapCnt_q   <= gapCnt_d;
            bitIdx_q   <= bitIdx_d;
            phase_q    <= phase_d;
            sclk_q     <= sclk_d;
            sdo_q      <= sdo_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_tx.sv
// tb_spi_cmd_tx: directed bench for spi_cmd_tx with a default instance and a
// CLK_DIV=1 / GAP_CYCLES=1 instance sharing clock and reset.
module tb_spi_cmd_tx;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        bit          fast;
        logic [15:0] expBits;
        int          expDone;
        longint      expPeriod;
    } vec_t;

    logic       iclk = 1'b0;
    logic       rstn = 1'b0;

    logic       cmdValid0 = 1'b0;
    logic       cmdReady0;
    logic [7:0] cmdAddr0 = 8'h00;
    logic [7:0] cmdData0 = 8'h00;
    logic       sclk0, serialOut0, busy0, done0;

    logic       cmdValid1 = 1'b0;
    logic       cmdReady1;
    logic [7:0] cmdAddr1 = 8'h00;
    logic [7:0] cmdData1 = 8'h00;
    logic       sclk1, serialOut1, busy1, done1;

    int          edges0 = 0;
    int          edges1 = 0;
    logic [15:0] cap0 = 16'h0000;
    logic [15:0] cap1 = 16'h0000;
    longint      lastEdge0 = 0;
    longint      lastEdge1 = 0;
    longint      period0 = 0;
    longint      period1 = 0;

    int passCount = 0;
    int totalCount = 0;

    vec_t vecs [5];

    always #5 iclk = ~iclk;

    spi_cmd_tx dut0 (
        .iclk       (iclk),
        .rstn       (rstn),
        .cmd_valid  (cmdValid0),
        .cmd_ready  (cmdReady0),
        .cmd_addr   (cmdAddr0),
        .cmd_data   (cmdData0),
        .sclk       (sclk0),
        .serial_out (serialOut0),
        .busy       (busy0),
        .done       (done0)
    );

    spi_cmd_tx #(
        .CLK_DIV    (1),
        .GAP_CYCLES (1)
    ) dut1 (
        .iclk       (iclk),
        .rstn       (rstn),
        .cmd_valid  (cmdValid1),
        .cmd_ready  (cmdReady1),
        .cmd_addr   (cmdAddr1),
        .cmd_data   (cmdData1),
        .sclk       (sclk1),
        .serial_out (serialOut1),
        .busy       (busy1),
        .done       (done1)
    );

    // Slave-side view of the default instance: sample serial_out on every sclk rise.
    always @(posedge sclk0) begin
        if (edges0 > 0) period0 = $time - lastEdge0;
        lastEdge0 = $time;
        cap0 = {serialOut0, cap0[15:1]};
        edges0++;
    end

    // Slave-side view of the fast instance.
    always @(posedge sclk1) begin
        if (edges1 > 0) period1 = $time - lastEdge1;
        lastEdge1 = $time;
        cap1 = {serialOut1, cap1[15:1]};
        edges1++;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        totalCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Send one command and follow it until cmd_ready returns, recording frame timing.
    task automatic applyStimulus(input bit fast, input logic [7:0] a, input logic [7:0] d,
                                 output int doneAt, output int readyAt, output logic [15:0] bits,
                                 output int edges, output longint period, output logic busyFirst);
        int es;
        @(negedge iclk);
        es = fast ? edges1 : edges0;
        if (fast) begin
            cmdValid1 = 1'b1; cmdAddr1 = a; cmdData1 = d;
        end else begin
            cmdValid0 = 1'b1; cmdAddr0 = a; cmdData0 = d;
        end
        @(posedge iclk);
        doneAt = -1;
        readyAt = -1;
        busyFirst = 1'b0;
        for (int n = 1; n <= 300 && readyAt < 0; n++) begin
            @(negedge iclk);
            if (n == 1) begin
                cmdValid0 = 1'b0;
                cmdValid1 = 1'b0;
                busyFirst = fast ? busy1 : busy0;
            end
            if ((fast ? done1 : done0) && doneAt < 0) doneAt = n;
            if ((fast ? cmdReady1 : cmdReady0) && readyAt < 0) readyAt = n;
        end
        bits   = fast ? cap1 : cap0;
        edges  = (fast ? edges1 : edges0) - es;
        period = fast ? period1 : period0;
    endtask

    initial begin
        int          doneAt, readyAt, edges, es, es2, lowCount, acceptAt, doneSeen;
        logic [15:0] bits, firstBits;
        longint      period;
        logic        busyFirst;

        vecs[0] = '{8'h28, 8'hEA, 1'b0, 16'hEA28, 68, 40};
        vecs[1] = '{8'h01, 8'hFF, 1'b0, 16'hFF01, 68, 40};
        vecs[2] = '{8'h02, 8'h00, 1'b0, 16'h0002, 68, 40};
        vecs[3] = '{8'h03, 8'h01, 1'b1, 16'h0103, 33, 20};
        vecs[4] = '{8'h80, 8'h81, 1'b1, 16'h8180, 33, 20};

        // Reset state, while held and after release.
        repeat (3) @(negedge iclk);
        checkOutput("rst_ready0", cmdReady0, 1);
        checkOutput("rst_sclk0", sclk0, 0);
        checkOutput("rst_sdo0", serialOut0, 0);
        checkOutput("rst_busy0", busy0, 0);
        checkOutput("rst_done0", done0, 0);
        checkOutput("rst_ready1", cmdReady1, 1);
        rstn = 1'b1;
        repeat (20) @(negedge iclk);
        checkOutput("idle_ready0", cmdReady0, 1);
        checkOutput("idle_busy0", busy0, 0);
        checkOutput("idle_sclk0", sclk0, 0);
        checkOutput("idle_edges0", edges0, 0);
        checkOutput("idle_edges1", edges1, 0);

        // Table of single frames on both instances.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].fast, vecs[i].addr, vecs[i].data,
                          doneAt, readyAt, bits, edges, period, busyFirst);
            $display("[TB] vector %0d addr=0x%0h data=0x%0h", i, vecs[i].addr, vecs[i].data);
            checkOutput("vec_bits", bits, vecs[i].expBits);
            checkOutput("vec_edges", edges, 16);
            checkOutput("vec_done_at", doneAt, vecs[i].expDone);
            checkOutput("vec_ready_at", readyAt, vecs[i].expDone + 1);
            checkOutput("vec_sclk_period", period, vecs[i].expPeriod);
            checkOutput("vec_busy", busyFirst, 1);
        end

        // Back-pressure: keep a second command valid during the whole first frame.
        @(negedge iclk);
        es = edges0;
        cmdValid0 = 1'b1; cmdAddr0 = 8'h28; cmdData0 = 8'hEA;
        @(posedge iclk);
        lowCount = 0;
        acceptAt = -1;
        firstBits = 16'h0000;
        for (int n = 1; n <= 300 && acceptAt < 0; n++) begin
            @(negedge iclk);
            if (n == 1) begin
                cmdAddr0 = 8'h55; cmdData0 = 8'hC3;
            end
            if (done0) firstBits = cap0;
            if (!cmdReady0) lowCount++;
            else acceptAt = n;
        end
        checkOutput("bp_ready_low_cycles", lowCount, 68);
        checkOutput("bp_accept_at", acceptAt, 69);
        checkOutput("bp_first_bits", firstBits, 16'hEA28);
        checkOutput("bp_first_edges", edges0 - es, 16);
        es2 = edges0;
        @(posedge iclk);
        @(negedge iclk);
        cmdValid0 = 1'b0;
        doneSeen = 0;
        for (int n = 0; n < 300 && doneSeen == 0; n++) begin
            @(negedge iclk);
            if (done0) doneSeen = 1;
        end
        checkOutput("bp_second_done", doneSeen, 1);
        checkOutput("bp_second_bits", cap0, 16'hC355);
        checkOutput("bp_second_edges", edges0 - es2, 16);
        repeat (2) @(negedge iclk);

        // Reset mid-frame, after the fifth rising edge.
        @(negedge iclk);
        es = edges0;
        cmdValid0 = 1'b1; cmdAddr0 = 8'h13; cmdData0 = 8'h5A;
        @(posedge iclk);
        @(negedge iclk);
        cmdValid0 = 1'b0;
        for (int n = 0; n < 300 && (edges0 - es) < 5; n++) begin
            @(negedge iclk);
        end
        checkOutput("mid_edges_before_reset", edges0 - es, 5);
        checkOutput("mid_sclk_before_reset", sclk0, 1);
        checkOutput("mid_sdo_before_reset", serialOut0, 1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_sclk_async", sclk0, 0);
        checkOutput("mid_sdo_async", serialOut0, 0);
        checkOutput("mid_busy_async", busy0, 0);
        checkOutput("mid_ready_async", cmdReady0, 1);
        repeat (2) @(negedge iclk);
        rstn = 1'b1;
        repeat (3) @(negedge iclk);
        applyStimulus(1'b0, 8'h13, 8'h5A, doneAt, readyAt, bits, edges, period, busyFirst);
        checkOutput("post_reset_bits", bits, 16'h5A13);
        checkOutput("post_reset_edges", edges, 16);
        checkOutput("post_reset_done_at", doneAt, 68);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
